// File: rtl/sic_alu_lock_arb_if.sv
// Lock-request and shared-ALU bundle between the SIC execute stages
// and the shared-ALU lock arbiter.
interface sic_alu_lock_arb_if #(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = 8
);
  localparam int OW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  logic [NUM_SICS-1:0]          sic_req;
  logic [NUM_SICS*ID_WIDTH-1:0] sic_req_issue_id;
  logic [NUM_SICS-1:0]          sic_release;
  logic [NUM_SICS*6-1:0]        sic_alu_op;
  logic [NUM_SICS*32-1:0]       sic_alu_a;
  logic [NUM_SICS*32-1:0]       sic_alu_b;
  logic [NUM_SICS-1:0]          sic_grant;
  logic [5:0]                   alu_op;
  logic [31:0]                  alu_a;
  logic [31:0]                  alu_b;
  logic                         lock_busy;
  logic [OW-1:0]                lock_owner;
  logic                         protocol_err;

  modport master (
    output sic_req, sic_req_issue_id, sic_release,
    output sic_alu_op, sic_alu_a, sic_alu_b,
    input  sic_grant, alu_op, alu_a, alu_b,
    input  lock_busy, lock_owner, protocol_err
  );

  modport slave (
    input  sic_req, sic_req_issue_id, sic_release,
    input  sic_alu_op, sic_alu_a, sic_alu_b,
    output sic_grant, alu_op, alu_a, alu_b,
    output lock_busy, lock_owner, protocol_err
  );
endinterface

// File: rtl/sic_alu_lock_arb.sv
// Shared-ALU lock arbiter: oldest-issue-ID grant, hold until release,
// idle-hold timeout and owner operand mux onto the shared ALU.
module sic_alu_lock_arb #(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = 8,
  parameter int TIMEOUT  = 64
) (
  input logic clk,
  input logic rst,
  sic_alu_lock_arb_if.slave bus
);
  localparam int OW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic {S_FREE, S_BUSY} state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [NUM_SICS-1:0]  own_oh;
  logic [NUM_SICS-1:0]  cand;
  logic [OW-1:0]        win;
  logic                 win_vld;
  logic [ID_WIDTH-1:0]  win_id;
  logic [ID_WIDTH-1:0]  cur_id;
  logic [ID_WIDTH-1:0]  diff;
  logic                 busy;
  logic                 own_req;
  logic                 own_rel;
  logic                 tmo;
  logic                 free_now;
  logic                 bad_rel;

  logic [5:0]           op_mux;
  logic [31:0]          a_mux;
  logic [31:0]          b_mux;

  assign busy = (state_q == S_BUSY);

  always_comb begin
    own_oh = '0;
    for (int i = 0; i < NUM_SICS; i++)
      own_oh[i] = busy && (owner_q == OW'(i));
  end

  assign own_req  = |(bus.sic_req & own_oh);
  assign own_rel  = |(bus.sic_release & own_oh);
  assign bad_rel  = |(bus.sic_release & ~own_oh);
  assign tmo      = busy && !own_req && !own_rel
                    && (cnt_q == CMAX);
  assign free_now = busy && (own_rel || tmo);

  // The current owner never competes: it either keeps the lock
  // or is the one giving it up this cycle.
  assign cand = bus.sic_req & ~own_oh;

  // Strictly-older replaces the best so far, so ties keep the lower index.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    win_id  = '0;
    cur_id  = '0;
    diff    = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      cur_id = bus.sic_req_issue_id[i*ID_WIDTH +: ID_WIDTH];
      diff   = cur_id - win_id;
      if (cand[i] && (!win_vld || diff[ID_WIDTH-1])) begin
        win     = OW'(i);
        win_vld = 1'b1;
        win_id  = cur_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FREE;
      owner_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    err_d   = err_q | bad_rel | tmo;
    unique case (state_q)
      S_FREE: begin
        if (win_vld) begin
          state_d = S_BUSY;
          owner_d = win;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (free_now) begin
          cnt_d = '0;
          if (win_vld) owner_d = win;
          else         state_d = S_FREE;
        end else if (own_req) begin
          cnt_d = '0;
        end else if (cnt_q != CMAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_comb begin
    op_mux = '0;
    a_mux  = '0;
    b_mux  = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      if (own_oh[i]) begin
        op_mux = bus.sic_alu_op[i*6 +: 6];
        a_mux  = bus.sic_alu_a[i*32 +: 32];
        b_mux  = bus.sic_alu_b[i*32 +: 32];
      end
    end
  end

  assign bus.sic_grant    = bus.sic_req & own_oh;
  assign bus.alu_op       = op_mux;
  assign bus.alu_a        = a_mux;
  assign bus.alu_b        = b_mux;
  assign bus.lock_busy    = busy;
  assign bus.lock_owner   = owner_q;
  assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_sic_alu_lock_arb.sv
// Directed bench for sic_alu_lock_arb: grant latency, age/wrap/tie
// priority, back-to-back handoff, abort, spurious release, timeout, reset.
module tb_sic_alu_lock_arb;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  sic_alu_lock_arb_if #(.NUM_SICS(4), .ID_WIDTH(8)) bus ();

  sic_alu_lock_arb #(
    .NUM_SICS(4),
    .ID_WIDTH(8),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    bus.sic_release = '0;
  endtask

  task automatic set_sic(input int i, input logic r,
                         input logic [7:0] id,
                         input logic [5:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
    bus.sic_req[i] = r;
    bus.sic_req_issue_id[i*8 +: 8] = id;
    bus.sic_alu_op[i*6 +: 6] = op;
    bus.sic_alu_a[i*32 +: 32] = a;
    bus.sic_alu_b[i*32 +: 32] = b;
  endtask

  task automatic drop(input int i, input logic rel);
    bus.sic_req[i] = 1'b0;
    bus.sic_release[i] = rel;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.sic_req = '0;
    bus.sic_req_issue_id = '0;
    bus.sic_release = '0;
    bus.sic_alu_op = '0;
    bus.sic_alu_a = '0;
    bus.sic_alu_b = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.sic_grant), 32'h0);
    chk("rst_busy", 32'(bus.lock_busy), 32'h0);
    chk("rst_owner", 32'(bus.lock_owner), 32'h0);
    chk("rst_err", 32'(bus.protocol_err), 32'h0);
    chk("rst_alu_a", bus.alu_a, 32'h0);

    // single request
    set_sic(0, 1'b1, 8'h05, 6'h03, 32'h1111, 32'h2222);
    #1;
    chk("acq_nogrant", 32'(bus.sic_grant), 32'h0);
    tick();
    #1;
    chk("one_busy", 32'(bus.lock_busy), 32'h1);
    chk("one_grant", 32'(bus.sic_grant), 32'h1);
    chk("one_op", 32'(bus.alu_op), 32'h3);
    chk("one_a", bus.alu_a, 32'h1111);
    chk("one_b", bus.alu_b, 32'h2222);
    tick();
    drop(0, 1'b1);
    #1;
    chk("one_rel_grant", 32'(bus.sic_grant), 32'h0);
    tick();
    #1;
    chk("one_free", 32'(bus.lock_busy), 32'h0);
    chk("one_free_a", bus.alu_a, 32'h0);

    // wrap-around age, back-to-back handoff
    set_sic(1, 1'b1, 8'hFE, 6'h01, 32'hA1, 32'hB1);
    set_sic(2, 1'b1, 8'h02, 6'h02, 32'hA2, 32'hB2);
    tick();
    #1;
    chk("wrap_owner", 32'(bus.lock_owner), 32'h1);
    chk("wrap_grant", 32'(bus.sic_grant), 32'h2);
    chk("wrap_a", bus.alu_a, 32'hA1);
    drop(1, 1'b1);
    tick();
    #1;
    chk("b2b_busy", 32'(bus.lock_busy), 32'h1);
    chk("b2b_owner", 32'(bus.lock_owner), 32'h2);
    chk("b2b_grant", 32'(bus.sic_grant), 32'h4);
    chk("b2b_b", bus.alu_b, 32'hB2);
    drop(2, 1'b1);
    tick();
    #1;
    chk("b2b_free", 32'(bus.lock_busy), 32'h0);
    chk("b2b_err", 32'(bus.protocol_err), 32'h0);

    // tie goes to lower index, then abort of the owner
    set_sic(0, 1'b1, 8'h10, 6'h04, 32'hC0, 32'hD0);
    set_sic(3, 1'b1, 8'h10, 6'h05, 32'hC3, 32'hD3);
    tick();
    #1;
    chk("tie_owner", 32'(bus.lock_owner), 32'h0);
    chk("tie_grant", 32'(bus.sic_grant), 32'h1);
    drop(0, 1'b0);
    #1;
    chk("abort_grant", 32'(bus.sic_grant), 32'h0);
    chk("abort_mux", bus.alu_a, 32'hC0);
    tick();
    bus.sic_release[0] = 1'b1;
    tick();
    #1;
    chk("abort_owner", 32'(bus.lock_owner), 32'h3);
    chk("abort_grant3", 32'(bus.sic_grant), 32'h8);
    drop(3, 1'b1);
    tick();
    #1;
    chk("abort_free", 32'(bus.lock_busy), 32'h0);
    chk("abort_err", 32'(bus.protocol_err), 32'h0);

    // spurious release from a non-owner
    set_sic(1, 1'b1, 8'h20, 6'h06, 32'hE1, 32'hF1);
    tick();
    bus.sic_release[2] = 1'b1;
    tick();
    #1;
    chk("spur_busy", 32'(bus.lock_busy), 32'h1);
    chk("spur_owner", 32'(bus.lock_owner), 32'h1);
    chk("spur_grant", 32'(bus.sic_grant), 32'h2);
    chk("spur_err", 32'(bus.protocol_err), 32'h1);
    drop(1, 1'b1);
    tick();
    #1;
    chk("spur_free", 32'(bus.lock_busy), 32'h0);
    chk("spur_sticky", 32'(bus.protocol_err), 32'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("clr_err", 32'(bus.protocol_err), 32'h0);

    // idle-hold timeout with TIMEOUT=4
    set_sic(0, 1'b1, 8'h30, 6'h07, 32'h33, 32'h44);
    tick();
    #1;
    chk("to_grant", 32'(bus.sic_grant), 32'h1);
    drop(0, 1'b0);
    tick();
    tick();
    tick();
    #1;
    chk("to_still_busy", 32'(bus.lock_busy), 32'h1);
    chk("to_err_pre", 32'(bus.protocol_err), 32'h0);
    tick();
    #1;
    chk("to_free", 32'(bus.lock_busy), 32'h0);
    chk("to_err", 32'(bus.protocol_err), 32'h1);

    // reset in the middle of a lock
    set_sic(2, 1'b1, 8'h40, 6'h08, 32'h55, 32'h66);
    tick();
    #1;
    chk("mid_owner", 32'(bus.lock_owner), 32'h2);
    chk("mid_a", bus.alu_a, 32'h55);
    rst = 1'b1;
    tick();
    #1;
    chk("mid_rst_busy", 32'(bus.lock_busy), 32'h0);
    chk("mid_rst_grant", 32'(bus.sic_grant), 32'h0);
    chk("mid_rst_owner", 32'(bus.lock_owner), 32'h0);
    chk("mid_rst_err", 32'(bus.protocol_err), 32'h0);
    chk("mid_rst_op", 32'(bus.alu_op), 32'h0);
    chk("mid_rst_a", bus.alu_a, 32'h0);
    chk("mid_rst_b", bus.alu_b, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
